// File: rtl/mult_sequencer_if.sv
// Start/abort request, counter flags and datapath strobes shared by the
// multiplier sequencer (slave side) and whatever drives it (master side).
interface mult_sequencer_if;
    logic start;
    logic abort;
    logic flag_SM;
    logic flag_mux;
    logic cnt_enable;
    logic cnt_sync_reset;
    logic load_operands;
    logic shift_en;
    logic retro_sel;
    logic product_capture;
    logic busy;
    logic done;
    logic error;

    modport master (
        output start, abort, flag_SM, flag_mux,
        input  cnt_enable, cnt_sync_reset, load_operands, shift_en,
               retro_sel, product_capture, busy, done, error
    );

    modport slave (
        input  start, abort, flag_SM, flag_mux,
        output cnt_enable, cnt_sync_reset, load_operands, shift_en,
               retro_sel, product_capture, busy, done, error
    );
endinterface

// File: rtl/mult_sequencer.sv
// Control FSM for the sequential shift-add multiplier: sequences load, run,
// capture and done, drives the external cycle counter, and watches for a hung counter.
module mult_sequencer #(
    parameter int WORD_LENGTH     = 17,
    parameter int NBitsForCounter = 5
) (
    input  logic            clk,
    input  logic            reset,
    mult_sequencer_if.slave bus
);
    localparam int              WD_W     = NBitsForCounter + 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WORD_LENGTH);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPTURE, DONE} state_t;

    state_t          state, state_next;
    logic [WD_W-1:0] wd;
    logic            error_q;
    logic            wd_clr, wd_inc, err_set, err_clr;
    logic            cnt_enable, cnt_sync_reset, load_operands, shift_en;
    logic            retro_sel, product_capture, busy, done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            wd      <= '0;
            error_q <= 1'b0;
        end else begin
            state <= state_next;
            if (wd_clr)
                wd <= '0;
            else if (wd_inc)
                wd <= wd + WD_W'(1);
            if (err_clr)
                error_q <= 1'b0;
            else if (err_set)
                error_q <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        wd_clr          = 1'b0;
        wd_inc          = 1'b0;
        err_set         = 1'b0;
        err_clr         = 1'b0;
        cnt_enable      = 1'b0;
        cnt_sync_reset  = 1'b0;
        load_operands   = 1'b0;
        shift_en        = 1'b0;
        retro_sel       = 1'b0;
        product_capture = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = LOAD;
                    err_clr    = 1'b1;
                end
            end
            LOAD: begin
                busy           = 1'b1;
                cnt_enable     = 1'b1;
                cnt_sync_reset = 1'b1;
                if (bus.abort) begin
                    state_next = IDLE;
                end else begin
                    load_operands = 1'b1;
                    retro_sel     = 1'b1;
                    wd_clr        = 1'b1;
                    state_next    = RUN;
                end
            end
            RUN: begin
                // Priority: abort, then counter terminal, then watchdog timeout.
                busy       = 1'b1;
                cnt_enable = 1'b1;
                wd_inc     = 1'b1;
                if (bus.abort) begin
                    cnt_sync_reset = 1'b1;
                    state_next     = IDLE;
                end else if (bus.flag_SM) begin
                    shift_en       = 1'b1;
                    retro_sel      = bus.flag_mux;
                    cnt_sync_reset = 1'b1;
                    state_next     = CAPTURE;
                end else if (wd == WD_LIMIT) begin
                    cnt_sync_reset = 1'b1;
                    err_set        = 1'b1;
                    state_next     = IDLE;
                end else begin
                    shift_en  = 1'b1;
                    retro_sel = bus.flag_mux;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (bus.abort) begin
                    cnt_enable     = 1'b1;
                    cnt_sync_reset = 1'b1;
                    state_next     = IDLE;
                end else begin
                    product_capture = 1'b1;
                    state_next      = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (bus.start) begin
                    state_next = LOAD;
                    err_clr    = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.cnt_enable      = cnt_enable;
    assign bus.cnt_sync_reset  = cnt_sync_reset;
    assign bus.load_operands   = load_operands;
    assign bus.shift_en        = shift_en;
    assign bus.retro_sel       = retro_sel;
    assign bus.product_capture = product_capture;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.error           = error_q;
endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with an attached cycle-counter model (W=17).
module tb_mult_sequencer;
    logic       clk;
    logic       reset;
    logic       stuck;
    logic [4:0] cnt;
    int         n_vec;
    int         n_err;

    mult_sequencer_if bus ();

    mult_sequencer #(.WORD_LENGTH(17), .NBitsForCounter(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier cycle counter sharing the sequencer's reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (bus.cnt_enable)
            cnt <= bus.cnt_sync_reset ? 5'd0 : cnt + 5'd1;
    end
    assign bus.flag_SM  = !stuck && (cnt == 5'd16);
    assign bus.flag_mux = (cnt <= 5'd1);

    // {cnt_enable, cnt_sync_reset, load_operands, shift_en, retro_sel,
    //  product_capture, busy, done, error}
    function automatic logic [8:0] outs();
        return {bus.cnt_enable, bus.cnt_sync_reset, bus.load_operands, bus.shift_en,
                bus.retro_sel, bus.product_capture, bus.busy, bus.done, bus.error};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic full_op(input string tag);
        int shifts;
        int busys;
        logic [8:0] e;
        shifts = 0;
        busys  = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        chk({tag, "_load"}, 64'(outs()), 64'(9'b111010100));
        busys += int'(bus.busy);
        for (int i = 0; i < 17; i++) begin
            tick();
            e = {1'b1, (i == 16), 1'b0, 1'b1, (i < 2), 1'b0, 1'b1, 1'b0, 1'b0};
            chk($sformatf("%s_run%0d", tag, i), 64'(outs()), 64'(e));
            shifts += int'(bus.shift_en);
            busys  += int'(bus.busy);
        end
        chk({tag, "_shifts"}, 64'(shifts), 64'd17);
        tick();
        chk({tag, "_capture"}, 64'(outs()), 64'(9'b000001100));
        busys += int'(bus.busy);
        chk({tag, "_busy_cycles"}, 64'(busys), 64'd19);
        tick();
        chk({tag, "_done"}, 64'(outs()), 64'(9'b000000010));
        tick();
        chk({tag, "_idle"}, 64'(outs()), 64'(9'b000000000));
    endtask

    initial begin
        logic [63:0] done_mask;
        logic [63:0] load_mask;
        n_vec     = 0;
        n_err     = 0;
        stuck     = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        reset     = 1'b0;
        #1;
        chk("reset_outs", 64'(outs()), 64'd0);
        #11;
        reset = 1'b1;
        tick();
        chk("idle_outs", 64'(outs()), 64'd0);

        full_op("single");

        // Back-to-back with start held high: LOAD follows DONE directly.
        done_mask = '0;
        load_mask = '0;
        bus.start = 1'b1;
        tick();
        chk("b2b_load0", 64'(bus.load_operands), 64'd1);
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (bus.done)          done_mask[c] = 1'b1;
            if (bus.load_operands) load_mask[c] = 1'b1;
        end
        chk("b2b_done_at", done_mask, (64'd1 << 19) | (64'd1 << 39));
        chk("b2b_load_at", load_mask, (64'd1 << 20) | (64'd1 << 40));
        // Abort while in LOAD.
        bus.start = 1'b0;
        bus.abort = 1'b1;
        #1;
        chk("abort_load_strobes", 64'({bus.cnt_enable, bus.cnt_sync_reset, bus.load_operands,
            bus.shift_en, bus.retro_sel, bus.product_capture, bus.done}), 64'(7'b1100000));
        tick();
        bus.abort = 1'b0;
        #1;
        chk("abort_load_idle", 64'(outs()), 64'd0);

        // Abort at RUN cycle 5.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("abort_pre_shift", 64'(bus.shift_en), 64'd1);
        bus.abort = 1'b1;
        #1;
        chk("abort_run_strobes", 64'({bus.cnt_enable, bus.cnt_sync_reset, bus.load_operands,
            bus.shift_en, bus.retro_sel, bus.product_capture, bus.done}), 64'(7'b1100000));
        tick();
        bus.abort = 1'b0;
        #1;
        chk("abort_run_idle", 64'(outs()), 64'd0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tick();
        chk("abort_idle_noeffect", 64'(outs()), 64'd0);
        full_op("after_abort");

        // Watchdog: counter never reaches terminal count.
        stuck     = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        #1;
        chk("wd_load", 64'(outs()), 64'(9'b111010100));
        for (int i = 0; i < 17; i++) begin
            tick();
            chk($sformatf("wd_run%0d", i), 64'(outs()),
                64'({1'b1, 1'b0, 1'b0, 1'b1, (i < 2), 1'b0, 1'b1, 1'b0, 1'b0}));
        end
        tick();
        chk("wd_timeout_strobes", 64'({bus.cnt_enable, bus.cnt_sync_reset, bus.shift_en,
            bus.product_capture, bus.done, bus.error}), 64'(6'b110000));
        tick();
        chk("wd_error_idle", 64'(outs()), 64'(9'b000000001));
        tick();
        chk("wd_error_sticky", 64'(outs()), 64'(9'b000000001));
        stuck = 1'b0;
        full_op("wd_recover");

        // Asynchronous reset in the middle of RUN.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("prereset_run", 64'(bus.shift_en), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outs", 64'(outs()), 64'd0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_held_outs", 64'(outs()), 64'd0);
        reset = 1'b1;
        tick();
        chk("post_reset_idle", 64'(outs()), 64'd0);
        full_op("post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
